// File: rtl/adder_issue_arbiter_if.sv
// Bus between two requesters, the shared 4-stage adder and the issue arbiter.
// slave: arbiter view. master: environment view (clients plus adder).
interface adder_issue_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ci;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ci;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_ci;
  logic [31:0] add_s;
  logic        add_co;
  logic        rsp0_valid;
  logic [31:0] rsp0_s;
  logic        rsp0_co;
  logic        rsp1_valid;
  logic [31:0] rsp1_s;
  logic        rsp1_co;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    input  add_s, add_co,
    output req0_ready, req1_ready,
    output add_a, add_b, add_ci,
    output rsp0_valid, rsp0_s, rsp0_co,
    output rsp1_valid, rsp1_s, rsp1_co,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    output add_s, add_co,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_ci,
    input  rsp0_valid, rsp0_s, rsp0_co,
    input  rsp1_valid, rsp1_s, rsp1_co,
    input  busy
  );
endinterface

// File: rtl/adder_issue_arbiter.sv
// Round-robin issue of two requesters into one pipelined adder. A tag shift
// register with the adder's latency steers each result back to its issuer.
// Per-requester credit counters cap the number of ops in flight.
module adder_issue_arbiter #(
  parameter int LAT     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_issue_arbiter_if.slave  bus
);

  localparam logic [3:0] MAX_C = 4'(MAX_OUT);

  logic [LAT-1:0]  tag_vld;
  logic [LAT-1:0]  tag_id;
  logic [1:0][3:0] cnt;
  logic            rr_ptr;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic [1:0]      rsp;
  logic            issue;
  logic            issue_id;

  // A requester may compete only while it has credit left.
  assign elig[0] = bus.req0_valid && (cnt[0] < MAX_C);
  assign elig[1] = bus.req1_valid && (cnt[1] < MAX_C);

  // Sole eligible side wins; on a tie rr_ptr picks the side.
  assign grant[0] = elig[0] && (!elig[1] || !rr_ptr);
  assign grant[1] = elig[1] && (!elig[0] ||  rr_ptr);
  assign issue    = |grant;
  assign issue_id = grant[1];

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  // Idle cycles leave req0 operands on the adder; no tag is issued for them.
  assign bus.add_a  = grant[1] ? bus.req1_a  : bus.req0_a;
  assign bus.add_b  = grant[1] ? bus.req1_b  : bus.req0_b;
  assign bus.add_ci = grant[1] ? bus.req1_ci : bus.req0_ci;

  // The tail tag lines up with the adder output holding that op's result.
  assign rsp[0] = tag_vld[LAT-1] && !tag_id[LAT-1];
  assign rsp[1] = tag_vld[LAT-1] &&  tag_id[LAT-1];

  assign bus.rsp0_valid = rsp[0];
  assign bus.rsp0_s     = bus.add_s;
  assign bus.rsp0_co    = bus.add_co;
  assign bus.rsp1_valid = rsp[1];
  assign bus.rsp1_s     = bus.add_s;
  assign bus.rsp1_co    = bus.add_co;
  assign bus.busy       = |tag_vld;

  // Tag pipe shifts every edge; no stall exists anywhere downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[LAT-2:0], issue};
      tag_id  <= {tag_id[LAT-2:0],  issue_id};
    end
  end

  // Credits: taken on issue, returned on response, net zero when both happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({grant[i], rsp[i]})
          2'b10:   cnt[i] <= cnt[i] + 4'd1;
          2'b01:   cnt[i] <= cnt[i] - 4'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Priority flips to the other side only after an actual issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr <= 1'b0;
    else if (issue) rr_ptr <= ~issue_id;
  end

endmodule

// File: tb/tb_adder_issue_arbiter.sv
// Bench for adder_issue_arbiter: behavioural 4-stage adder, scoreboard of
// expected responses filled on each observed handshake, directed scenarios.
module tb_adder_issue_arbiter;
  localparam int LAT     = 4;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_rsp = 0;

  adder_issue_arbiter_if bus ();

  adder_issue_arbiter #(.LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined adder: result of operands captured at edge k is on s after edge k+3.
  logic [32:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_ci};
    for (int n = 1; n < LAT; n++) apipe[n] <= apipe[n-1];
  end
  assign bus.add_s  = apipe[LAT-1][31:0];
  assign bus.add_co = apipe[LAT-1][32];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic [31:0] s;
    logic        co;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  logic [32:0] sum;
  logic [31:0] got_s;
  logic        got_co;
  int          n0, n1;

  // Monitor: retire responses against the queue, then record new issues.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_one", {63'd0, bus.rsp0_valid & bus.rsp1_valid}, 64'd0);
        chk("rsp_pending", {63'd0, sbq.size() > 0}, 64'd1);
        if (sbq.size() > 0) begin
          e      = sbq.pop_front();
          got_s  = e.id ? bus.rsp1_s  : bus.rsp0_s;
          got_co = e.id ? bus.rsp1_co : bus.rsp0_co;
          chk("rsp_id",  {63'd0, bus.rsp1_valid}, {63'd0, e.id});
          chk("rsp_lat", 64'(cyc - e.cyc), 64'(LAT));
          chk("rsp_s",   {32'd0, got_s}, {32'd0, e.s});
          chk("rsp_co",  {63'd0, got_co}, {63'd0, e.co});
          n_rsp++;
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        sum = {1'b0, bus.req0_a} + {1'b0, bus.req0_b} + {32'd0, bus.req0_ci};
        sbq.push_back('{id: 1'b0, s: sum[31:0], co: sum[32], cyc: cyc});
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sum = {1'b0, bus.req1_a} + {1'b0, bus.req1_b} + {32'd0, bus.req1_ci};
        sbq.push_back('{id: 1'b1, s: sum[31:0], co: sum[32], cyc: cyc});
      end
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        n0 = 0;
        n1 = 0;
        foreach (sbq[k]) if (sbq[k].id) n1++; else n0++;
        chk("credit", {63'd0, (n0 <= MAX_OUT) && (n1 <= MAX_OUT)}, 64'd1);
      end
    end
  end

  // One cycle of stimulus; returns the readies seen mid-cycle.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic c0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic c1,
                      output logic r0, output logic r1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_ci = c0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_ci = c1;
    @(negedge clk);
    r0 = bus.req0_ready;
    r1 = bus.req1_ready;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_rsp",  {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
    chk("rst_rdy",  {62'd0, bus.req1_ready, bus.req0_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic r0, r1;
    logic [5:0] rdy3;
    int base;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_ci = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_ci = 0;
    @(posedge clk); #1;
    do_reset();

    // 1: single op with carry out
    base = n_rsp;
    step(1, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, r0, r1);
    chk("t1_rdy0", {63'd0, r0}, 64'd1);
    idle(6);
    chk("t1_nrsp", 64'(n_rsp - base), 64'd1);
    @(negedge clk);
    chk("t1_busy", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;

    // 2: contention alternates starting with req0
    do_reset();
    base = n_rsp;
    for (int i = 0; i < 8; i++) begin
      step(1, $urandom, $urandom, 1'($urandom_range(1)), 1, $urandom, $urandom, 1'($urandom_range(1)), r0, r1);
      chk("t2_g0", {63'd0, r0}, {63'd0, i % 2 == 0});
      chk("t2_g1", {63'd0, r1}, {63'd0, i % 2 == 1});
    end
    idle(6);
    chk("t2_nrsp", 64'(n_rsp - base), 64'd8);

    // 3: credit limit on a lone requester
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 32'(i), 32'(i * 3), 0, 0, 0, 0, 0, r0, r1);
      rdy3[i] = r0;
    end
    chk("t3_rdy", {58'd0, rdy3}, 64'b101111);
    for (int i = 0; i < 8; i++) step(1, $urandom, $urandom, 0, 0, 0, 0, 0, r0, r1);
    idle(8);

    // 4: carry in on req1, plain add on req0
    do_reset();
    base = n_rsp;
    step(1, 32'd5, 32'd7, 0, 1, 32'h7FFF_FFFF, 32'd0, 1, r0, r1);
    chk("t4_g0", {62'd0, r1, r0}, 64'b01);
    step(0, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'd0, 1, r0, r1);
    chk("t4_g1", {62'd0, r1, r0}, 64'b10);
    idle(6);
    chk("t4_nrsp", 64'(n_rsp - base), 64'd2);

    // 5: reset with three ops in flight
    for (int i = 0; i < 3; i++) step(1, 32'(i + 1), 32'd9, 0, 0, 0, 0, 0, r0, r1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_norsp", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 64'd0);
      chk("t5_busy",  {63'd0, bus.busy}, 64'd0);
      @(posedge clk); #1;
    end
    step(1, 32'd1, 32'd2, 0, 1, 32'd3, 32'd4, 0, r0, r1);
    chk("t5_rr", {62'd0, r1, r0}, 64'b01);
    idle(6);

    // 6: idle keeps everything quiet and rr_ptr unchanged
    base = n_rsp;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_busy", {63'd0, bus.busy}, 64'd0);
      @(posedge clk); #1;
    end
    chk("t6_nrsp", 64'(n_rsp - base), 64'd0);
    step(1, 32'd10, 32'd20, 0, 1, 32'd30, 32'd40, 1, r0, r1);
    chk("t6_rr", {62'd0, r1, r0}, 64'b10);
    idle(6);
    chk("end_q", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
